// File: rtl/mem_io_responder.sv
// Memory-side responder for the byte-wide CPU memory bus.
// RAM below the IO window, plus UART TX/RX FIFOs and a halt flag in the IO window.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   mem_a/mem_wr/mem_wdata  byte request from the memory controller
//   mem_rdata               load byte, valid one cycle after its address
//   io_buffer_full          TX FIFO can take at most one more byte
//   tx_data/tx_valid/tx_ready  TX FIFO head towards the UART
//   rx_data/rx_valid        received UART bytes
//   program_end             sticky, set by a store to 0x30004
//   tx_overflow             sticky, set when an IO store was dropped
module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_end,
    output logic        tx_overflow
);

    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam int TCW = TXW + 1;
    localparam int RCW = RXW + 1;

    // Address decode (only a[17:0] is meaningful)
    logic io_win;
    logic hit_uart;
    logic hit_end;
    logic unused_hi;

    assign io_win    = (mem_a[17:16] == 2'b11);
    assign hit_uart  = io_win && (mem_a[15:0] == 16'h0000);
    assign hit_end   = io_win && (mem_a[15:0] == 16'h0004);
    assign unused_hi = ^mem_a[31:18];

    // RAM: plain synchronous array, no reset so it maps onto block RAM
    logic [7:0] ram [2**RAM_AW];
    logic [7:0] ram_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in && mem_wr && !io_win)
            ram[mem_a[RAM_AW-1:0]] <= mem_wdata;
        ram_q <= ram[mem_a[RAM_AW-1:0]];
    end

    // Output select is registered with reset so an in-flight read is dropped
    logic       rd_ram;
    logic [7:0] io_q;

    assign mem_rdata = rd_ram ? ram_q : io_q;

    // TX FIFO
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TXW-1:0] tx_wp;
    logic [TXW-1:0] tx_rp;
    logic [TCW-1:0] tx_cnt;
    logic [TCW-1:0] tx_cnt_nx;
    logic           tx_req;
    logic           tx_pop;
    logic           tx_push;
    logic           tx_full;

    assign tx_full   = (tx_cnt == TCW'(TX_DEPTH));
    assign tx_valid  = (tx_cnt != '0);
    assign tx_data   = tx_mem[tx_rp];
    assign tx_req    = mem_wr && hit_uart;
    assign tx_pop    = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign tx_push   = tx_req && (!tx_full || tx_pop);
    assign tx_cnt_nx = tx_cnt + TCW'(tx_push) - TCW'(tx_pop);

    always_ff @(posedge clk_in) begin
        if (tx_push)
            tx_mem[tx_wp] <= mem_wdata;
    end

    // RX FIFO
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RXW-1:0] rx_wp;
    logic [RXW-1:0] rx_rp;
    logic [RCW-1:0] rx_cnt;
    logic           rx_pop;
    logic           rx_push;
    logic           rx_full;

    assign rx_full = (rx_cnt == RCW'(RX_DEPTH));
    assign rx_pop  = !mem_wr && hit_uart && (rx_cnt != '0);
    assign rx_push = rx_valid && (!rx_full || rx_pop);

    always_ff @(posedge clk_in) begin
        if (rx_push)
            rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wp          <= '0;
            tx_rp          <= '0;
            tx_cnt         <= '0;
            rx_wp          <= '0;
            rx_rp          <= '0;
            rx_cnt         <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
            program_end    <= 1'b0;
            rd_ram         <= 1'b0;
            io_q           <= 8'h00;
        end else begin
            if (tx_push)
                tx_wp <= tx_wp + TXW'(1);
            if (tx_pop)
                tx_rp <= tx_rp + TXW'(1);
            tx_cnt <= tx_cnt_nx;
            // Threshold one below depth covers the store already in flight
            io_buffer_full <= (tx_cnt_nx >= TCW'(TX_DEPTH - 1));
            if (tx_req && !tx_push)
                tx_overflow <= 1'b1;

            if (rx_push)
                rx_wp <= rx_wp + RXW'(1);
            if (rx_pop)
                rx_rp <= rx_rp + RXW'(1);
            rx_cnt <= rx_cnt + RCW'(rx_push) - RCW'(rx_pop);

            if (mem_wr && hit_end)
                program_end <= 1'b1;

            rd_ram <= !mem_wr && !io_win;
            io_q   <= rx_pop ? rx_mem[rx_rp] : 8'h00;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder.
// Load bytes and TX bytes are queued at drive time and checked when they appear.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_wdata = '0;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        program_end;
    logic        tx_overflow;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_end    (program_end),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;
    int tx_seen = 0;

    logic [7:0] rd_q [$];
    logic [7:0] tx_q [$];
    logic       rd_chk = 1'b0;
    logic       chk_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Read scoreboard: result of cycle t is checked in cycle t+1
    always @(posedge clk_in) chk_pend <= rd_chk;

    always @(negedge clk_in) begin
        if (chk_pend) begin
            if (rd_q.size() == 0)
                check("rd_underflow", 32'(mem_rdata), 32'hdead);
            else
                check("mem_rdata", 32'(mem_rdata), 32'(rd_q.pop_front()));
        end
    end

    // TX scoreboard: every accepted head byte must match the push order
    always @(negedge clk_in) begin
        if (tx_valid && tx_ready) begin
            tx_seen++;
            if (tx_q.size() == 0)
                check("tx_extra", 32'(tx_data), 32'hdead);
            else
                check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
        end
    end

    task automatic op(input logic [31:0] a, input logic wr, input logic [7:0] wd,
                      input logic chk, input logic [7:0] ex,
                      input logic rv, input logic [7:0] rd);
        @(posedge clk_in);
        #1;
        mem_a     = a;
        mem_wr    = wr;
        mem_wdata = wd;
        rd_chk    = chk;
        rx_valid  = rv;
        rx_data   = rd;
        if (chk)
            rd_q.push_back(ex);
        if (wr && a[17:0] == 18'h30000)
            tx_q.push_back(wd);
    endtask

    task automatic idle();
        op(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        op(a, 1'b1, d, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] ex);
        op(a, 1'b0, 8'h00, 1'b1, ex, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        mem_a  = '0;
        mem_wr = 1'b0;
        rd_chk = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        tx_q.delete();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    // Wait for the TX queue to drain with a cycle bound
    task automatic drain(input string tag);
        int k;
        k = 0;
        tx_ready = 1'b1;
        while ((tx_valid || tx_q.size() != 0) && k < 64) begin
            @(negedge clk_in);
            k++;
        end
        if (k >= 64)
            check({tag, "_timeout"}, 32'(k), 32'd0);
        @(posedge clk_in);
        #1;
        tx_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_rdata", 32'(mem_rdata), 32'h0);
        check("rst_pend", 32'(program_end), 32'h0);
        check("rst_ovf", 32'(tx_overflow), 32'h0);
        check("rst_txv", 32'(tx_valid), 32'h0);
        check("rst_full", 32'(io_buffer_full), 32'h0);

        // 1: RAM write then back-to-back reads
        wr(32'h10, 8'hA5);
        wr(32'h11, 8'h3C);
        rd(32'h10, 8'hA5);
        rd(32'h11, 8'h3C);
        op(32'h12, 1'b1, 8'h77, 1'b1, 8'h00, 1'b0, 8'h00);
        rd(32'h12, 8'h77);
        rd(32'h30008, 8'h00);
        rd(32'h10, 8'hA5);
        idle();

        // 2: TX fill, threshold, overflow, drain in order
        for (int i = 0; i < 14; i++)
            wr(32'h30000, 8'h10 + 8'(i));
        idle();
        @(negedge clk_in);
        check("full_at14", 32'(io_buffer_full), 32'h0);
        wr(32'h30000, 8'h1E);
        idle();
        @(negedge clk_in);
        check("full_at15", 32'(io_buffer_full), 32'h1);
        wr(32'h30000, 8'h1F);
        idle();
        @(negedge clk_in);
        check("ovf_at16", 32'(tx_overflow), 32'h0);
        @(posedge clk_in);
        #1;
        mem_a = 32'h30000;
        mem_wr = 1'b1;
        mem_wdata = 8'hEE;
        idle();
        @(negedge clk_in);
        check("ovf_at17", 32'(tx_overflow), 32'h1);
        check("tx_head", 32'(tx_data), 32'h10);
        tx_seen = 0;
        drain("tx2");
        check("tx2_count", 32'(tx_seen), 32'd16);
        check("tx2_empty", 32'(tx_valid), 32'h0);

        // 3: push and pop together while full
        do_reset();
        for (int i = 0; i < 16; i++)
            wr(32'h30000, 8'h50 + 8'(i));
        wr(32'h30000, 8'h99);
        tx_ready = 1'b1;
        idle();
        tx_ready = 1'b0;
        @(negedge clk_in);
        check("tx3_ovf", 32'(tx_overflow), 32'h0);
        check("tx3_full", 32'(io_buffer_full), 32'h1);
        check("tx3_head", 32'(tx_data), 32'h51);
        tx_seen = 0;
        drain("tx3");
        check("tx3_count", 32'(tx_seen), 32'd16);

        // 4: RX FIFO
        do_reset();
        op(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41);
        op(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h42);
        rd(32'h30000, 8'h41);
        rd(32'h30000, 8'h42);
        rd(32'h30000, 8'h00);
        op(32'h30000, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h77);
        rd(32'h30000, 8'h77);
        rd(32'h30000, 8'h00);
        for (int i = 0; i < 9; i++)
            op(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h80 + 8'(i));
        for (int i = 0; i < 8; i++)
            rd(32'h30000, 8'h80 + 8'(i));
        rd(32'h30000, 8'h00);
        idle();

        // 5: program_end sticky, cleared by reset
        wr(32'h30000, 8'h5A);
        wr(32'h30004, 8'h00);
        idle();
        @(negedge clk_in);
        check("pend_set", 32'(program_end), 32'h1);
        repeat (3) idle();
        @(negedge clk_in);
        check("pend_hold", 32'(program_end), 32'h1);
        check("pend_txv", 32'(tx_valid), 32'h1);
        rd(32'h10, 8'hA5);
        do_reset();
        @(negedge clk_in);
        check("r5_pend", 32'(program_end), 32'h0);
        check("r5_txv", 32'(tx_valid), 32'h0);
        check("r5_rdata", 32'(mem_rdata), 32'h0);

        // 6: reset in the middle of a RAM read burst
        for (int i = 0; i < 4; i++)
            wr(32'h100 + 32'(i), 8'hB0 + 8'(i));
        rd(32'h100, 8'hB0);
        rd(32'h101, 8'hB1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        mem_a = 32'h102;
        mem_wr = 1'b0;
        rd_chk = 1'b1;
        rd_q.push_back(8'h00);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        rd_chk = 1'b0;
        mem_a = 32'h0;
        rd(32'h103, 8'hB3);
        rd(32'h102, 8'hB2);
        rd(32'h10, 8'hA5);
        idle();
        repeat (2) @(posedge clk_in);
        #1;
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t expected completion", $time);
        $fatal(1);
    end

endmodule
